rs_encoder: RTL and testbench
=============================

# rs_encoder

Systematic RS(255,239) encoder over GF(2^8), the transmit-side counterpart to the decoder chain. It accepts 239 message symbols through a valid/ready handshake and streams them out unchanged. It then appends 16 parity symbols computed by a 16-stage LFSR, producing frames the decoder accepts directly: active-low `sync`, one symbol per cycle. It sits at the source end of the link or the test harness, upstream of the channel model and the decoder.

## Interface
- `n`, 255, codeword length in symbols
- `k`, 239, message length in symbols
- `t`, 8, correctable symbols; parity length is 2t = 16
- `m`, 8, symbol width
- `clk_in`  input  1  system clock; all logic on the rising edge
- `rst_in`  input  1  synchronous, active-high reset
- `in_valid`  input  1  `data_in` holds a message symbol
- `in_ready`  output  1  encoder can accept a message symbol
- `data_in`  input  m  message symbol
- `data_out`  output  m  encoded symbol
- `sync_out`  output  1  active-low; low on every cycle `data_out` carries a codeword symbol
- `frame_done`  output  1  one-cycle pulse coincident with the last parity symbol

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02.
- Generator polynomial g(x) = ∏_{i=0}^{15}(x + α^i), degree 16, monic. Coefficients g0..g15 are fixed constants and the multipliers are constant GF multipliers.
- Parity registers `p[0..15]`, all zero at reset and at frame start.
- Output order: message symbol 0 first, which is the highest-degree coefficient; parity `p[15]` first, `p[0]` last.
- FSM states:
  - MSG: `in_ready` = 1 and a symbol counter runs 0..k-1.
  - PARITY: `in_ready` = 0 and a counter runs 0..15.
- MSG, on accept (`in_valid & in_ready`):
  - fb = `data_in` ^ `p[15]`
  - `p[j]` ← `p[j-1]` ^ g_j·fb for j = 1..15
  - `p[0]` ← g0·fb
  - `data_out` ← `data_in`, `sync_out` ← 0
  - counter increments
- MSG, accept of symbol k-1: after the update, the state goes to PARITY and the LFSR is not cleared.
- MSG, no accept: `sync_out` ← 1 and `data_out` holds its previous value (a gap). The counter and LFSR are unchanged.
- PARITY, each cycle:
  - `data_out` ← `p[15]`, `sync_out` ← 0
  - `p[j]` ← `p[j-1]`, `p[0]` ← 0
  - the input is ignored
- PARITY, count 15: `frame_done` ← 1, the state goes to MSG with all `p` = 0 and the counter = 0.
- Reset values: `data_out` = 0, `sync_out` = 1, `frame_done` = 0, `in_ready` = 0 during reset, state = MSG, counters and `p` = 0.
- Reset mid-frame: the partial frame is discarded and no parity is emitted. Normal behaviour restarts with symbol 0 on the first cycle after reset deasserts.
- Back-to-back frames: a message symbol may be accepted on the cycle immediately after the last parity cycle.

## Timing
- Message latency: 1 cycle from accept to appearance on `data_out` with `sync_out` low.
- Parity: the 16 parity symbols occupy the 16 cycles immediately following the last message symbol output. There are no gaps and no stalls.
- `in_ready` is low for exactly 16 cycles per frame. It drops in the cycle after symbol k-1 is accepted.
- Frame throughput with continuous `in_valid`: 255 output symbols every 255 cycles, so `sync_out` stays low continuously.
- The decoder requires gap-free frames, so upstream must hold `in_valid` high for the whole message. Gaps are legal here but appear as `sync_out`-high cycles.
- `frame_done` is high in the same cycle that `data_out` = `p[0]` of the frame.

## Configuration
- `RSENC_ERR_INJECT_EN` defined:
  - adds input `err_mask` (m bits)
  - `data_out` = encoded symbol ^ `err_mask`, registered alongside it, on every `sync_out`-low cycle
  - the LFSR always uses the clean `data_in`
  - used to exercise decoder correction
- Undefined: the port is absent and the output is the clean codeword.

## Test plan
- All-zero message, 239 symbols with continuous `in_valid` -> 255 zero output symbols; `sync_out` low for 255 cycles; `frame_done` on cycle 255; `in_ready` low for 16 cycles.
- Message with symbol 238 = 0x01 and all others 0 -> parity out in order = g15, g14, …, g0.
- Random message with `in_valid` toggling every other cycle -> the output message equals the input in order, with `sync_out` high on gap cycles. Parity equals the gap-free encoding of the same message. Polynomial check: every codeword evaluates to 0 at α^0..α^15.
- Reset asserted at message symbol 100, then a fresh all-0x01 message -> no parity is emitted for the aborted frame, and the new frame's parity matches the golden model.
- Two back-to-back random frames with continuous `in_valid` -> `sync_out` stays low for 510 cycles and each frame's parity matches the golden model.
- With `RSENC_ERR_INJECT_EN` -> for each frame, inject 8 random nonzero `err_mask` values at random positions and feed the encoder output into the decoder. The decoder output must equal the clean codeword. With 9 errors, the mismatch is flagged as expected.

Source files
------------

// File: rtl/rs_encoder_if.sv
// Message handshake and codeword output stream of the RS(255,239) encoder.
// With RSENC_ERR_INJECT_EN defined the interface also carries err_mask.
interface rs_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       sync_out;
  logic       frame_done;
`ifdef RSENC_ERR_INJECT_EN
  logic [7:0] err_mask;

  modport master (
    output in_valid, data_in, err_mask,
    input  in_ready, data_out, sync_out, frame_done
  );
  modport slave (
    input  in_valid, data_in, err_mask,
    output in_ready, data_out, sync_out, frame_done
  );
`else
  modport master (
    output in_valid, data_in,
    input  in_ready, data_out, sync_out, frame_done
  );
  modport slave (
    input  in_valid, data_in,
    output in_ready, data_out, sync_out, frame_done
  );
`endif
endinterface

// File: rtl/rs_encoder.sv
// Systematic RS(255,239) encoder over GF(2^8) (poly 0x11D), 16-stage parity LFSR.
// Optional RSENC_ERR_INJECT_EN XORs err_mask onto every emitted symbol.
module rs_encoder (
  input  logic         clk_in,
  input  logic         rst_in,
  rs_encoder_if.slave  bus
);
  localparam int K    = 239;
  localparam int NPAR = 16;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  // g(x) = prod (x + alpha^i), i = 0..15; the monic x^16 term is dropped.
  function automatic logic [NPAR-1:0][7:0] gen_poly();
    logic [NPAR:0][7:0] g;
    logic [7:0]         root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    return g[NPAR-1:0];
  endfunction

  localparam logic [NPAR-1:0][7:0] G = gen_poly();

  typedef enum logic {S_MSG, S_PARITY} state_t;

  state_t               state;
  logic [7:0]           cnt;
  logic [NPAR-1:0][7:0] p;
  logic [7:0]           data_q;
  logic                 sync_q;
  logic                 done_q;
  logic [7:0]           fb;
  logic [7:0]           mask;
  logic                 accept;

`ifdef RSENC_ERR_INJECT_EN
  assign mask = bus.err_mask;
`else
  assign mask = 8'h00;
`endif

  assign bus.in_ready   = (state == S_MSG) && !rst_in;
  assign accept         = bus.in_valid && bus.in_ready;
  assign fb             = bus.data_in ^ p[NPAR-1];
  assign bus.data_out   = data_q;
  assign bus.sync_out   = sync_q;
  assign bus.frame_done = done_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state  <= S_MSG;
      cnt    <= 8'd0;
      p      <= '0;
      data_q <= 8'h00;
      sync_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_MSG: begin
          if (accept) begin
            for (int j = NPAR - 1; j > 0; j--) p[j] <= p[j-1] ^ gf_mul(G[j], fb);
            p[0]   <= gf_mul(G[0], fb);
            data_q <= bus.data_in ^ mask;
            sync_q <= 1'b0;
            if (cnt == 8'(K - 1)) begin
              state <= S_PARITY;
              cnt   <= 8'd0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            sync_q <= 1'b1;
          end
        end
        S_PARITY: begin
          data_q <= p[NPAR-1] ^ mask;
          sync_q <= 1'b0;
          for (int j = NPAR - 1; j > 0; j--) p[j] <= p[j-1];
          p[0] <= 8'h00;
          if (cnt == 8'(NPAR - 1)) begin
            done_q <= 1'b1;
            state  <= S_MSG;
            cnt    <= 8'd0;
            p      <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_MSG;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_encoder.sv
// Self-checking bench for rs_encoder: random messages against a long-division RS model.
module tb_rs_encoder;
  logic clk_in = 1'b0;
  logic rst_in;

  rs_encoder_if bus();

  rs_encoder dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

`ifdef RSENC_ERR_INJECT_EN
  initial bus.err_mask = 8'h00;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [7:0] exp_t [0:254];
  int         log_t [0:255];
  logic [7:0] g_ref [0:16];
  logic [7:0] msg   [2][239];
  logic [7:0] cw    [2][255];

  bit         mon_en = 1'b0;
  logic       log_sync [$];
  logic       log_done [$];
  logic       log_ready[$];
  logic [7:0] log_data [$];
  logic [7:0] out_sym  [$];
  logic       out_done [$];

  always @(negedge clk_in) begin
    if (mon_en) begin
      log_sync.push_back(bus.sync_out);
      log_done.push_back(bus.frame_done);
      log_ready.push_back(bus.in_ready);
      log_data.push_back(bus.data_out);
    end
  end

  // ---------------- reference model ----------------
  task automatic init_tables();
    int x;
    x = 1;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = 8'(x);
      log_t[x] = i;
      x = x * 2;
      if (x > 255) x = x ^ 'h11D;
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  task automatic compute_gen();
    logic [7:0] prod [0:16];
    for (int d = 0; d <= 16; d++) g_ref[d] = 8'h00;
    g_ref[0] = 8'h01;
    for (int i = 0; i < 16; i++) begin
      for (int d = 0; d <= 16; d++) prod[d] = 8'h00;
      for (int d = 0; d < 16; d++) begin
        prod[d+1] = prod[d+1] ^ g_ref[d];
        prod[d]   = prod[d] ^ gmul(g_ref[d], exp_t[i]);
      end
      for (int d = 0; d <= 16; d++) g_ref[d] = prod[d];
    end
  endtask

  // codeword = message followed by (m(x) * x^16 mod g(x)), highest degree first
  task automatic encode(input int f);
    logic [7:0] work [0:254];
    logic [7:0] q;
    for (int i = 0; i < 255; i++) work[i] = (i < 239) ? msg[f][i] : 8'h00;
    for (int i = 0; i < 239; i++) begin
      q = work[i];
      if (q != 8'h00)
        for (int d = 0; d <= 16; d++) work[i+16-d] = work[i+16-d] ^ gmul(q, g_ref[d]);
    end
    for (int i = 0; i < 255; i++) cw[f][i] = (i < 239) ? msg[f][i] : work[i];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    log_sync.delete(); log_done.delete(); log_ready.delete(); log_data.delete();
  endtask

  task automatic extract();
    out_sym.delete(); out_done.delete();
    foreach (log_sync[i]) begin
      if (log_sync[i] === 1'b0) begin
        out_sym.push_back(log_data[i]);
        out_done.push_back(log_done[i]);
      end
    end
  endtask

  task automatic send(input int f, input bit gaps, input int nsym);
    int idx = 0;
    int budget = 0;
    bit tog = 1'b0;
    while (idx < nsym && budget < 2000) begin
      @(negedge clk_in);
      tog = ~tog;
      if (!gaps || tog) begin
        bus.in_valid = 1'b1;
        bus.data_in  = msg[f][idx];
      end else begin
        bus.in_valid = 1'b0;
        bus.data_in  = 8'($urandom);
      end
      if (bus.in_valid && bus.in_ready === 1'b1) idx++;
      budget++;
    end
    if (idx < nsym) begin
      nvec++; nerr++;
      $display("FAIL send_timeout accepted %0d required %0d", idx, nsym);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk_in);
      bus.in_valid = 1'b0;
      if (bus.frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      nvec++; nerr++;
      $display("FAIL frame_done_timeout got none required one within 40 cycles");
    end
    repeat (3) @(negedge clk_in);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in = 8'h00;
    repeat (3) @(negedge clk_in);
    nvec++; if (bus.data_out !== 8'h00) begin nerr++; $display("FAIL rst_data_out got %h want 00", bus.data_out); end
    nvec++; if (bus.sync_out !== 1'b1) begin nerr++; $display("FAIL rst_sync_out got %b want 1", bus.sync_out); end
    nvec++; if (bus.frame_done !== 1'b0) begin nerr++; $display("FAIL rst_frame_done got %b want 0", bus.frame_done); end
    nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL rst_in_ready got %b want 0", bus.in_ready); end
    rst_in = 1'b0;
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_zero_frame();
    int run = 0, maxrun = 0, rdy_low = 0, nz = 0, done_idx = -1, done_cnt = 0;
    for (int i = 0; i < 239; i++) msg[0][i] = 8'h00;
    clear_logs(); #1 mon_en = 1'b1;
    send(0, 1'b0, 239);
    wait_done();
    #1 mon_en = 1'b0;
    extract();
    foreach (log_sync[i]) begin
      run = (log_sync[i] === 1'b0) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
      if (log_ready[i] === 1'b0) rdy_low++;
    end
    foreach (out_sym[i]) begin
      if (out_sym[i] !== 8'h00) nz++;
      if (out_done[i] === 1'b1) begin done_cnt++; if (done_idx < 0) done_idx = i; end
    end
    nvec++; if (out_sym.size() != 255) begin nerr++; $display("FAIL zero_sym_count got %0d want 255", out_sym.size()); end
    nvec++; if (nz != 0) begin nerr++; $display("FAIL zero_nonzero_syms got %0d want 0", nz); end
    nvec++; if (maxrun != 255) begin nerr++; $display("FAIL zero_sync_run got %0d want 255", maxrun); end
    nvec++; if (done_idx != 254 || done_cnt != 1) begin nerr++; $display("FAIL zero_frame_done idx %0d cnt %0d want 254 1", done_idx, done_cnt); end
    nvec++; if (rdy_low != 16) begin nerr++; $display("FAIL zero_ready_low got %0d want 16", rdy_low); end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 239; i++) msg[0][i] = 8'h00;
    msg[0][238] = 8'h01;
    clear_logs(); #1 mon_en = 1'b1;
    send(0, 1'b0, 239);
    wait_done();
    #1 mon_en = 1'b0;
    extract();
    nvec++;
    if (out_sym.size() != 255) begin
      nerr++; $display("FAIL impulse_sym_count got %0d want 255", out_sym.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        nvec++;
        if (out_sym[239+j] !== g_ref[15-j]) begin
          nerr++; $display("FAIL impulse_parity[%0d] got %h want g%0d=%h", j, out_sym[239+j], 15 - j, g_ref[15-j]);
        end
      end
    end
  endtask

  task automatic test_gapped();
    int first = -1, last = -1, seen = 0, bad = 0;
    logic [7:0] acc;
    for (int i = 0; i < 239; i++) msg[0][i] = 8'($urandom);
    encode(0);
    clear_logs(); #1 mon_en = 1'b1;
    send(0, 1'b1, 239);
    wait_done();
    #1 mon_en = 1'b0;
    extract();
    foreach (log_sync[i]) begin
      if (log_sync[i] === 1'b0) begin
        if (first < 0) first = i;
        seen++;
        if (seen == 239) last = i;
      end
    end
    nvec++; if (last - first + 1 - 239 != 238) begin nerr++; $display("FAIL gap_sync_high got %0d want 238", last - first + 1 - 239); end
    nvec++;
    if (out_sym.size() != 255) begin
      nerr++; $display("FAIL gap_sym_count got %0d want 255", out_sym.size());
    end else begin
      for (int i = 0; i < 255; i++) if (out_sym[i] !== cw[0][i]) begin
        bad++;
        if (bad < 4) $display("FAIL gap_sym[%0d] got %h want %h", i, out_sym[i], cw[0][i]);
      end
      nvec++; if (bad != 0) begin nerr++; $display("FAIL gap_codeword got %0d bad symbols want 0", bad); end
      for (int r = 0; r < 16; r++) begin
        acc = 8'h00;
        for (int i = 0; i < 255; i++) acc = gmul(acc, exp_t[r]) ^ out_sym[i];
        nvec++; if (acc !== 8'h00) begin nerr++; $display("FAIL gap_syndrome[%0d] got %h want 00", r, acc); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    for (int i = 0; i < 239; i++) msg[0][i] = 8'($urandom);
    clear_logs(); #1 mon_en = 1'b1;
    send(0, 1'b0, 100);
    @(negedge clk_in);
    rst_in = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    repeat (20) @(negedge clk_in);
    #1 mon_en = 1'b0;
    extract();
    nvec++; if (out_sym.size() != 100) begin nerr++; $display("FAIL abort_sym_count got %0d want 100", out_sym.size()); end
    for (int i = 0; i < 239; i++) msg[0][i] = 8'h01;
    encode(0);
    clear_logs(); #1 mon_en = 1'b1;
    send(0, 1'b0, 239);
    wait_done();
    #1 mon_en = 1'b0;
    extract();
    nvec++;
    if (out_sym.size() != 255) begin
      nerr++; $display("FAIL after_rst_sym_count got %0d want 255", out_sym.size());
    end else begin
      for (int i = 0; i < 255; i++) if (out_sym[i] !== cw[0][i]) begin
        bad++;
        if (bad < 4) $display("FAIL after_rst_sym[%0d] got %h want %h", i, out_sym[i], cw[0][i]);
      end
      nvec++; if (bad != 0) begin nerr++; $display("FAIL after_rst_codeword got %0d bad symbols want 0", bad); end
    end
  endtask

  task automatic test_back_to_back();
    int run = 0, maxrun = 0, bad = 0, d0 = -1, d1 = -1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 239; i++) msg[f][i] = 8'($urandom);
      encode(f);
    end
    clear_logs(); #1 mon_en = 1'b1;
    send(0, 1'b0, 239);
    send(1, 1'b0, 239);
    wait_done();
    #1 mon_en = 1'b0;
    extract();
    foreach (log_sync[i]) begin
      run = (log_sync[i] === 1'b0) ? run + 1 : 0;
      if (run > maxrun) maxrun = run;
    end
    foreach (out_done[i]) if (out_done[i] === 1'b1) begin
      if (d0 < 0) d0 = i; else if (d1 < 0) d1 = i;
    end
    nvec++; if (maxrun != 510) begin nerr++; $display("FAIL b2b_sync_run got %0d want 510", maxrun); end
    nvec++; if (d0 != 254 || d1 != 509) begin nerr++; $display("FAIL b2b_frame_done got %0d,%0d want 254,509", d0, d1); end
    nvec++;
    if (out_sym.size() != 510) begin
      nerr++; $display("FAIL b2b_sym_count got %0d want 510", out_sym.size());
    end else begin
      for (int f = 0; f < 2; f++) begin
        bad = 0;
        for (int i = 0; i < 255; i++) if (out_sym[f*255+i] !== cw[f][i]) begin
          bad++;
          if (bad < 4) $display("FAIL b2b_f%0d_sym[%0d] got %h want %h", f, i, out_sym[f*255+i], cw[f][i]);
        end
        nvec++; if (bad != 0) begin nerr++; $display("FAIL b2b_f%0d_codeword got %0d bad symbols want 0", f, bad); end
      end
    end
  endtask

  initial begin
    rst_in = 1'b1;
    bus.in_valid = 1'b0;
    bus.data_in = 8'h00;
    init_tables();
    compute_gen();
    test_reset();
    test_zero_frame();
    test_impulse();
    test_gapped();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
